// File: rtl/onepulser_pkg.sv
// Shared definitions for the multi-channel push-button one-pulser:
// FSM state encoding and counter sizing helpers.
package onepulser_pkg;

    typedef logic [1:0] pulser_state_t;

    localparam pulser_state_t ST_IDLE = 2'd0;
    localparam pulser_state_t ST_FIRE = 2'd1;
    localparam pulser_state_t ST_HELD = 2'd2;

    // Bits needed for a counter that holds 0 .. max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onepulse_channel.sv
// One push-button channel: 2-flop synchroniser, debounce counter, and the
// IDLE/FIRE/HELD pulse FSM with optional auto-repeat.
module onepulse_channel
    import onepulser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    input  logic ch_en,
    output logic pulse,
    output logic level
);

    localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = max_of(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic                level_q, level_d;
    pulser_state_t       state_q, state_d;
    logic [RPT_W-1:0]    rpt_cnt_q, rpt_cnt_d;
    logic                rpt_again_q, rpt_again_d;
    logic [RPT_W-1:0]    rpt_target;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_cnt_q    <= '0;
            level_q     <= 1'b0;
            state_q     <= ST_IDLE;
            rpt_cnt_q   <= '0;
            rpt_again_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
            state_q     <= state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_again_q <= rpt_again_d;
        end
    end

    // The counter only advances on consecutive mismatch cycles; the
    // DEBOUNCE_CYCLES-th one flips level instead of counting further.
    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rpt_target = rpt_again_q ? PERIOD_LAST : DELAY_LAST;

    // rpt_cnt counts cycles since the last FIRE, so hitting target-1 in HELD
    // places the next FIRE exactly target cycles after the previous one.
    always_comb begin
        state_d     = state_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_again_d = rpt_again_q;
        case (state_q)
            ST_IDLE: begin
                if (level_q && ch_en) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d   = ST_HELD;
                rpt_cnt_d = RPT_W'(1);
            end
            ST_HELD: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end else if (REPEAT_EN != 0) begin
                    if (rpt_cnt_q == rpt_target) begin
                        state_d     = ST_FIRE;
                        rpt_again_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!ch_en) begin
            state_d = ST_IDLE;
        end
        if (state_d == ST_IDLE) begin
            rpt_cnt_d   = '0;
            rpt_again_d = 1'b0;
        end
    end

    assign pulse = (state_q == ST_FIRE);
    assign level = level_q;

endmodule

// File: rtl/multi_onepulser.sv
// Multi-channel debounced one-pulser: one independent channel per button
// plus a combinational OR of all pulses.
module multi_onepulser #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] level,
    output logic                any_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        onepulse_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .btn_in (btn_in[i]),
            .ch_en  (ch_en[i]),
            .pulse  (pulse[i]),
            .level  (level[i])
        );
    end

    assign any_pulse = |pulse;

endmodule
